// File: rtl/arb_pkg.sv
// Shared constants for the round-robin arbiter: state encoding, default sizing
// and the hold-counter width used when ARB_TIMEOUT_EN is defined.
package arb_pkg;

    localparam logic ARB_IDLE  = 1'b0;
    localparam logic ARB_GRANT = 1'b1;

    localparam int ARB_N_DEF        = 4;
    localparam int ARB_MAX_HOLD_DEF = 8;
    localparam int ARB_CNT_W        = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: lowest index at or after base with req set and mask clear,
// found by rotate, priority-encode, un-rotate. Purely combinational.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = ARB_N_DEF,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    input  logic [IDW-1:0] base,
    output logic           hit,
    output logic [IDW-1:0] idx
);

    logic [N-1:0]   cand;
    logic [N-1:0]   rot;
    logic [IDW-1:0] ridx;
    logic [IDW:0]   sum;

    always_comb begin
        cand = req & ~mask;
        // bit k of rot is candidate (base + k) mod N
        rot  = N'({cand, cand} >> base);
        hit  = |rot;
        ridx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) ridx = IDW'(k);
        end
        sum = {1'b0, ridx} + {1'b0, base};
        if (sum >= (IDW + 1)'(N)) sum = sum - (IDW + 1)'(N);
        idx = sum[IDW-1:0];
    end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// N-requester round-robin arbiter with grant locking and same-edge handoff.
// Optional owner preemption after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_fsm
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEF,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("rr_arbiter_fsm: N must be in 2..16");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_arbiter_fsm: MAX_HOLD must be in 1..255");
    end

    logic           state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] owner_d;
    logic           new_grant;
    logic           owner_req;
    logic           hold_expired;
    logic           pick_hit;
    logic [IDW-1:0] pick_idx;
    logic [N-1:0]   gnt_d;
    logic [IDW-1:0] id_d;
    logic           vld_d;

    // Masking with the current grant lets the same picker serve both the idle
    // search and the handoff/preempt search (gnt is zero while idle).
    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req  (req),
        .mask (gnt),
        .base (ptr_q),
        .hit  (pick_hit),
        .idx  (pick_idx)
    );

    assign owner_req = |(req & gnt);

`ifdef ARB_TIMEOUT_EN
    localparam logic [ARB_CNT_W-1:0] HOLD_MAX = ARB_CNT_W'(MAX_HOLD);
    logic [ARB_CNT_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset)                                      cnt_q <= '0;
        else if (new_grant)                             cnt_q <= '0;
        else if (state_q == ARB_GRANT && cnt_q != HOLD_MAX) cnt_q <= cnt_q + 1'b1;
    end

    // Preempt only when someone else is waiting; otherwise the count saturates.
    assign hold_expired = (cnt_q == HOLD_MAX) && pick_hit;
`else
    assign hold_expired = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt       <= gnt_d;
            gnt_valid <= vld_d;
            gnt_id    <= id_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = gnt_id;
        new_grant = 1'b0;
        if (state_q == ARB_IDLE) begin
            if (pick_hit) begin
                state_d   = ARB_GRANT;
                new_grant = 1'b1;
            end
        end else if (!owner_req || hold_expired) begin
            if (pick_hit) new_grant = 1'b1;
            else          state_d   = ARB_IDLE;
        end
        if (new_grant) begin
            owner_d = pick_idx;
            ptr_d   = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // Output logic (registered above)
    always_comb begin
        gnt_d = '0;
        id_d  = '0;
        vld_d = (state_d == ARB_GRANT);
        if (vld_d) begin
            gnt_d = N'(1) << owner_d;
            id_d  = owner_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Self-checking bench for rr_arbiter_fsm (N=4, MAX_HOLD=3): vector table plus
// hand sequences for locking or timeout, expected grants via a scoreboard queue.
module tb_rr_arbiter_fsm;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req   = '0;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] exp_q[$];

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] exp_gnt;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter_fsm #(.N(N), .MAX_HOLD(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 clock = ~clock;

    function automatic logic [IDW-1:0] idx_of(input logic [N-1:0] g);
        logic [IDW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (g[i]) r = IDW'(i);
        return r;
    endfunction

    task automatic check(input string name);
        logic [N-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got gnt=%b", name, gnt);
            return;
        end
        e = exp_q.pop_front();
        if (gnt !== e || gnt_valid !== (|e) || gnt_id !== idx_of(e)) begin
            failures++;
            $display("FAIL %s: got gnt=%b valid=%b id=%0d, expected gnt=%b valid=%b id=%0d",
                     name, gnt, gnt_valid, gnt_id, e, |e, idx_of(e));
        end
    endtask

    // Drive away from the active edge, sample 1 time unit after it.
    task automatic apply(input logic rst, input logic [N-1:0] r, input logic [N-1:0] e,
                         input string name);
        @(negedge clock);
        reset = rst;
        req   = r;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        check(name);
    endtask

    task automatic add(input logic rst, input logic [N-1:0] r, input logic [N-1:0] e);
        vec_t v;
        v.rst = rst; v.req = r; v.exp_gnt = e;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held, then first grant and rotation with no idle handoff
        add(1, 4'b1111, 4'b0000);
        add(1, 4'b1111, 4'b0000);
        add(0, 4'b1111, 4'b0001);
        add(0, 4'b1110, 4'b0010);
        add(0, 4'b1101, 4'b0100);
        add(0, 4'b1011, 4'b1000);
        add(0, 4'b0111, 4'b0001);   // ptr wrapped 3 -> 0
        add(0, 4'b1111, 4'b0001);   // locked
        // release with nothing pending, then wrap search from ptr=2
        add(0, 4'b0010, 4'b0010);
        add(0, 4'b0000, 4'b0000);
        add(0, 4'b0011, 4'b0001);
        add(0, 4'b0000, 4'b0000);
        add(0, 4'b0101, 4'b0100);   // simultaneous in idle, ptr=1 picks 2
        // reset mid-grant must clear ptr (stale ptr=3 would pick 3)
        add(1, 4'b1101, 4'b0000);
        add(0, 4'b1100, 4'b0100);
        add(0, 4'b1000, 4'b1000);
        add(1, 4'b1000, 4'b0000);
        add(0, 4'b1000, 4'b1000);
        add(0, 4'b0000, 4'b0000);
        // request dropped before grant is not remembered
        add(0, 4'b0001, 4'b0001);
        add(0, 4'b0011, 4'b0001);
        add(0, 4'b0000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i].rst, vecs[i].req, vecs[i].exp_gnt, $sformatf("vec%0d", i));

`ifdef ARB_TIMEOUT_EN
        apply(1, 4'b0000, 4'b0000, "to_reset");
        for (int k = 0; k < 16; k++)
            apply(0, 4'b0011, ((k / 4) % 2 == 1) ? 4'b0010 : 4'b0001, $sformatf("to_alt%0d", k));
        apply(0, 4'b0001, 4'b0001, "to_solo_handoff");
        for (int k = 0; k < 10; k++)
            apply(0, 4'b0001, 4'b0001, $sformatf("to_solo%0d", k));
        apply(0, 4'b0011, 4'b0010, "to_saturated_preempt");
`else
        apply(1, 4'b0000, 4'b0000, "lock_reset");
        apply(0, 4'b0100, 4'b0100, "lock_grant2");
        for (int k = 0; k < 20; k++)
            apply(0, 4'b1111, 4'b0100, $sformatf("lock%0d", k));
        apply(0, 4'b1011, 4'b1000, "lock_release");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
